// File: rtl/icache_linefill_rx.sv
// Collects BEAT_NUM data beats of one outstanding linefill, writes the full line into the data RAM,
// then pulses linefill_done to the owning MSHR entry. States: IDLE | COLLECT | WRITE | DONE.
module icache_linefill_rx #(
  parameter int MSHR_ENTRY_NUM = 8,
  parameter int TXNID_W        = 3,
  parameter int IDX_W          = 7,
  parameter int BEAT_NUM       = 4,
  parameter int BEAT_W         = 128
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         txreq_hs,
  input  logic [TXNID_W-1:0]           txreq_txnid,
  input  logic [IDX_W-1:0]             txreq_index,
  input  logic                         txreq_way,
  input  logic                         rxdat_vld,
  output logic                         rxdat_rdy,
  input  logic [TXNID_W-1:0]           rxdat_txnid,
  input  logic [BEAT_W-1:0]            rxdat_data,
  input  logic                         rxdat_last,
  output logic                         dataram_wr_vld,
  input  logic                         dataram_wr_rdy,
  output logic [IDX_W-1:0]             dataram_wr_index,
  output logic                         dataram_wr_way,
  output logic [BEAT_NUM*BEAT_W-1:0]   dataram_wr_data,
  output logic [MSHR_ENTRY_NUM-1:0]    linefill_done,
  output logic [MSHR_ENTRY_NUM-1:0]    pend_vec,
  output logic                         err_unexp,
  output logic                         err_proto
);

  localparam int CNT_W = $clog2(BEAT_NUM);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          beat_cnt_q, beat_cnt_d;
  logic [TXNID_W-1:0]        cur_txnid_q, cur_txnid_d;
  logic [MSHR_ENTRY_NUM-1:0] pend_q, pend_d;
  logic                      err_unexp_q, err_unexp_d;
  logic                      err_proto_q, err_proto_d;
  logic                      rxdat_rdy_q, rxdat_rdy_d;
  logic                      wr_vld_q, wr_vld_d;
  logic [MSHR_ENTRY_NUM-1:0] done_q, done_d;
  logic [IDX_W-1:0]          idx_tbl_q [MSHR_ENTRY_NUM];
  logic [IDX_W-1:0]          idx_tbl_d [MSHR_ENTRY_NUM];
  logic                      way_tbl_q [MSHR_ENTRY_NUM];
  logic                      way_tbl_d [MSHR_ENTRY_NUM];
  logic [BEAT_W-1:0]         beat_buf_q [BEAT_NUM];
  logic [BEAT_W-1:0]         beat_buf_d [BEAT_NUM];
  logic [IDX_W-1:0]          wr_index_q, wr_index_d;
  logic                      wr_way_q, wr_way_d;
  logic                      beat_acc;
  logic                      beat_final;

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    cur_txnid_d = cur_txnid_q;
    pend_d      = pend_q;
    err_unexp_d = err_unexp_q;
    err_proto_d = err_proto_q;
    idx_tbl_d   = idx_tbl_q;
    way_tbl_d   = way_tbl_q;
    beat_buf_d  = beat_buf_q;
    wr_index_d  = wr_index_q;
    wr_way_d    = wr_way_q;
    beat_acc    = rxdat_vld && rxdat_rdy_q;
    beat_final  = (beat_cnt_q == CNT_W'(BEAT_NUM - 1));

    case (state_q)
      IDLE: begin
        if (beat_acc) begin
          if (!pend_q[rxdat_txnid]) begin
            err_unexp_d = 1'b1;
          end else begin
            beat_buf_d[0] = rxdat_data;
            beat_cnt_d    = CNT_W'(1);
            cur_txnid_d   = rxdat_txnid;
            state_d       = COLLECT;
            if (rxdat_last) err_proto_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (beat_acc) begin
          if (rxdat_txnid != cur_txnid_q) begin
            err_proto_d = 1'b1;
          end else begin
            beat_buf_d[beat_cnt_q] = rxdat_data;
            if (rxdat_last != beat_final) err_proto_d = 1'b1;
            // Length comes from the counter; rxdat_last only feeds the error check.
            if (beat_final) begin
              beat_cnt_d = '0;
              state_d    = WRITE;
              wr_index_d = idx_tbl_q[cur_txnid_q];
              wr_way_d   = way_tbl_q[cur_txnid_q];
            end else begin
              beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
          end
        end
      end
      WRITE: begin
        if (dataram_wr_rdy) state_d = DONE;
      end
      DONE: begin
        pend_d[cur_txnid_q] = 1'b0;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Snoop applied last so a re-request in DONE keeps its pending bit.
    if (txreq_hs) begin
      if (pend_q[txreq_txnid] && !(state_q == DONE && txreq_txnid == cur_txnid_q))
        err_proto_d = 1'b1;
      pend_d[txreq_txnid]    = 1'b1;
      idx_tbl_d[txreq_txnid] = txreq_index;
      way_tbl_d[txreq_txnid] = txreq_way;
    end

    rxdat_rdy_d = (state_d == IDLE) || (state_d == COLLECT);
    wr_vld_d    = (state_d == WRITE);
    done_d      = (state_d == DONE) ? (MSHR_ENTRY_NUM'(1) << cur_txnid_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      cur_txnid_q <= '0;
      pend_q      <= '0;
      err_unexp_q <= 1'b0;
      err_proto_q <= 1'b0;
      rxdat_rdy_q <= 1'b0;
      wr_vld_q    <= 1'b0;
      done_q      <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      cur_txnid_q <= cur_txnid_d;
      pend_q      <= pend_d;
      err_unexp_q <= err_unexp_d;
      err_proto_q <= err_proto_d;
      rxdat_rdy_q <= rxdat_rdy_d;
      wr_vld_q    <= wr_vld_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    idx_tbl_q  <= idx_tbl_d;
    way_tbl_q  <= way_tbl_d;
    beat_buf_q <= beat_buf_d;
    wr_index_q <= wr_index_d;
    wr_way_q   <= wr_way_d;
  end

  for (genvar k = 0; k < BEAT_NUM; k++) begin : g_wr_data
    assign dataram_wr_data[k*BEAT_W +: BEAT_W] = beat_buf_q[k];
  end

  assign rxdat_rdy        = rxdat_rdy_q;
  assign dataram_wr_vld   = wr_vld_q;
  assign dataram_wr_index = wr_index_q;
  assign dataram_wr_way   = wr_way_q;
  assign linefill_done    = done_q;
  assign pend_vec         = pend_q;
  assign err_unexp        = err_unexp_q;
  assign err_proto        = err_proto_q;

endmodule

// File: tb/tb_icache_linefill_rx.sv
// Directed bench for icache_linefill_rx: inputs change on negedge, outputs checked on negedge.
module tb_icache_linefill_rx;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         txreq_hs = 1'b0;
  logic [2:0]   txreq_txnid = '0;
  logic [6:0]   txreq_index = '0;
  logic         txreq_way = 1'b0;
  logic         rxdat_vld = 1'b0;
  logic         rxdat_rdy;
  logic [2:0]   rxdat_txnid = '0;
  logic [127:0] rxdat_data = '0;
  logic         rxdat_last = 1'b0;
  logic         dataram_wr_vld;
  logic         dataram_wr_rdy = 1'b1;
  logic [6:0]   dataram_wr_index;
  logic         dataram_wr_way;
  logic [511:0] dataram_wr_data;
  logic [7:0]   linefill_done;
  logic [7:0]   pend_vec;
  logic         err_unexp;
  logic         err_proto;

  int checks = 0;
  int passes = 0;

  logic [127:0] ba = {4{32'hAAAA_AAAA}};
  logic [127:0] bb = {4{32'hBBBB_BBBB}};
  logic [127:0] bc = {4{32'hCCCC_CCCC}};
  logic [127:0] bd = {4{32'hDDDD_DDDD}};
  logic [127:0] bx = {4{32'h1234_5678}};

  icache_linefill_rx dut (
    .clk(clk), .rst_n(rst_n),
    .txreq_hs(txreq_hs), .txreq_txnid(txreq_txnid), .txreq_index(txreq_index), .txreq_way(txreq_way),
    .rxdat_vld(rxdat_vld), .rxdat_rdy(rxdat_rdy), .rxdat_txnid(rxdat_txnid),
    .rxdat_data(rxdat_data), .rxdat_last(rxdat_last),
    .dataram_wr_vld(dataram_wr_vld), .dataram_wr_rdy(dataram_wr_rdy),
    .dataram_wr_index(dataram_wr_index), .dataram_wr_way(dataram_wr_way),
    .dataram_wr_data(dataram_wr_data),
    .linefill_done(linefill_done), .pend_vec(pend_vec),
    .err_unexp(err_unexp), .err_proto(err_proto)
  );

  always #5 clk = ~clk;

  // Stimulus helpers: each starts and ends on a negedge, consuming one cycle.
  task automatic snoop(input logic [2:0] id, input logic [6:0] idx, input logic way);
    txreq_hs = 1'b1; txreq_txnid = id; txreq_index = idx; txreq_way = way;
    @(posedge clk); @(negedge clk);
    txreq_hs = 1'b0;
  endtask

  task automatic beat(input logic [2:0] id, input logic [127:0] d, input logic last);
    rxdat_vld = 1'b1; rxdat_txnid = id; rxdat_data = d; rxdat_last = last;
    @(posedge clk); @(negedge clk);
    rxdat_vld = 1'b0; rxdat_last = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (rxdat_rdy !== 1'b0) $display("FAIL rst_rdy got=%b exp=0", rxdat_rdy); else passes++;
    checks++; if (dataram_wr_vld !== 1'b0) $display("FAIL rst_wr_vld got=%b exp=0", dataram_wr_vld); else passes++;
    checks++; if (pend_vec !== 8'h00) $display("FAIL rst_pend got=%h exp=00", pend_vec); else passes++;
    checks++; if (linefill_done !== 8'h00) $display("FAIL rst_done got=%h exp=00", linefill_done); else passes++;
    checks++; if ({err_unexp, err_proto} !== 2'b00) $display("FAIL rst_err got=%b exp=00", {err_unexp, err_proto}); else passes++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (rxdat_rdy !== 1'b1) $display("FAIL rst_rdy_after got=%b exp=1", rxdat_rdy); else passes++;
  endtask

  task automatic test_basic_line();
    snoop(3'd2, 7'h15, 1'b1);
    checks++; if (pend_vec !== 8'h04) $display("FAIL basic_pend_set got=%h exp=04", pend_vec); else passes++;
    beat(3'd2, ba, 1'b0); beat(3'd2, bb, 1'b0); beat(3'd2, bc, 1'b0); beat(3'd2, bd, 1'b1);
    checks++; if (dataram_wr_vld !== 1'b1) $display("FAIL basic_wr_vld got=%b exp=1", dataram_wr_vld); else passes++;
    checks++; if (dataram_wr_data !== {bd, bc, bb, ba}) $display("FAIL basic_wr_data got=%h exp=%h", dataram_wr_data, {bd, bc, bb, ba}); else passes++;
    checks++; if ({dataram_wr_way, dataram_wr_index} !== {1'b1, 7'h15}) $display("FAIL basic_wr_addr got=%b/%h exp=1/15", dataram_wr_way, dataram_wr_index); else passes++;
    checks++; if (rxdat_rdy !== 1'b0) $display("FAIL basic_rdy_write got=%b exp=0", rxdat_rdy); else passes++;
    checks++; if (linefill_done !== 8'h00) $display("FAIL basic_done_early got=%h exp=00", linefill_done); else passes++;
    @(negedge clk);
    checks++; if (linefill_done !== 8'h04) $display("FAIL basic_done got=%h exp=04", linefill_done); else passes++;
    checks++; if (dataram_wr_vld !== 1'b0) $display("FAIL basic_wr_vld_drop got=%b exp=0", dataram_wr_vld); else passes++;
    checks++; if (rxdat_rdy !== 1'b0) $display("FAIL basic_rdy_done got=%b exp=0", rxdat_rdy); else passes++;
    @(negedge clk);
    checks++; if (linefill_done !== 8'h00) $display("FAIL basic_done_pulse got=%h exp=00", linefill_done); else passes++;
    checks++; if (rxdat_rdy !== 1'b1) $display("FAIL basic_rdy_back got=%b exp=1", rxdat_rdy); else passes++;
    checks++; if (pend_vec !== 8'h00) $display("FAIL basic_pend_clr got=%h exp=00", pend_vec); else passes++;
    checks++; if ({err_unexp, err_proto} !== 2'b00) $display("FAIL basic_err got=%b exp=00", {err_unexp, err_proto}); else passes++;
  endtask

  task automatic test_unexpected();
    beat(3'd5, bx, 1'b0);
    checks++; if (err_unexp !== 1'b1) $display("FAIL unexp_flag got=%b exp=1", err_unexp); else passes++;
    checks++; if (err_proto !== 1'b0) $display("FAIL unexp_proto got=%b exp=0", err_proto); else passes++;
    checks++; if (rxdat_rdy !== 1'b1) $display("FAIL unexp_idle_rdy got=%b exp=1", rxdat_rdy); else passes++;
    repeat (5) begin
      @(negedge clk);
      checks++; if (dataram_wr_vld !== 1'b0) $display("FAIL unexp_no_write got=%b exp=0", dataram_wr_vld); else passes++;
    end
    // A 4-beat line for txnid 6 must start from beat 0, proving the dropped beat left the FSM in IDLE.
    snoop(3'd6, 7'h09, 1'b0);
    beat(3'd6, bd, 1'b0); beat(3'd6, bc, 1'b0); beat(3'd6, bb, 1'b0);
    checks++; if (dataram_wr_vld !== 1'b0) $display("FAIL unexp_early_write got=%b exp=0", dataram_wr_vld); else passes++;
    beat(3'd6, ba, 1'b1);
    checks++; if (dataram_wr_data !== {ba, bb, bc, bd}) $display("FAIL unexp_line got=%h exp=%h", dataram_wr_data, {ba, bb, bc, bd}); else passes++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_interleave();
    do_reset();
    snoop(3'd1, 7'h22, 1'b0);
    snoop(3'd3, 7'h33, 1'b1);
    checks++; if (pend_vec !== 8'h0A) $display("FAIL intl_pend got=%h exp=0a", pend_vec); else passes++;
    beat(3'd1, ba, 1'b0); beat(3'd1, bb, 1'b0);
    beat(3'd3, bx, 1'b0);
    checks++; if (err_proto !== 1'b1) $display("FAIL intl_proto got=%b exp=1", err_proto); else passes++;
    beat(3'd1, bc, 1'b0);
    checks++; if (dataram_wr_vld !== 1'b0) $display("FAIL intl_early_write got=%b exp=0", dataram_wr_vld); else passes++;
    beat(3'd1, bd, 1'b1);
    checks++; if (dataram_wr_data !== {bd, bc, bb, ba}) $display("FAIL intl_data got=%h exp=%h", dataram_wr_data, {bd, bc, bb, ba}); else passes++;
    checks++; if ({dataram_wr_way, dataram_wr_index} !== {1'b0, 7'h22}) $display("FAIL intl_addr got=%b/%h exp=0/22", dataram_wr_way, dataram_wr_index); else passes++;
    @(negedge clk);
    checks++; if (linefill_done !== 8'h02) $display("FAIL intl_done got=%h exp=02", linefill_done); else passes++;
    @(negedge clk);
    checks++; if (pend_vec !== 8'h08) $display("FAIL intl_pend_after got=%h exp=08", pend_vec); else passes++;
  endtask

  task automatic test_backpressure();
    do_reset();
    dataram_wr_rdy = 1'b0;
    snoop(3'd6, 7'h7F, 1'b0);
    beat(3'd6, bb, 1'b0); beat(3'd6, ba, 1'b0); beat(3'd6, bd, 1'b0); beat(3'd6, bc, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checks++; if (dataram_wr_vld !== 1'b1) $display("FAIL bp_wr_vld[%0d] got=%b exp=1", i, dataram_wr_vld); else passes++;
      checks++; if (dataram_wr_data !== {bc, bd, ba, bb} || dataram_wr_index !== 7'h7F) $display("FAIL bp_payload[%0d] got=%h/%h", i, dataram_wr_index, dataram_wr_data); else passes++;
      checks++; if (rxdat_rdy !== 1'b0 || linefill_done !== 8'h00) $display("FAIL bp_rdy_done[%0d] got=%b/%h exp=0/00", i, rxdat_rdy, linefill_done); else passes++;
      if (i < 4) @(negedge clk);
    end
    dataram_wr_rdy = 1'b1;
    @(negedge clk);
    checks++; if (linefill_done !== 8'h40) $display("FAIL bp_done got=%h exp=40", linefill_done); else passes++;
    checks++; if (dataram_wr_vld !== 1'b0) $display("FAIL bp_wr_vld_drop got=%b exp=0", dataram_wr_vld); else passes++;
    @(negedge clk);
  endtask

  task automatic test_reset_midline();
    do_reset();
    snoop(3'd4, 7'h11, 1'b0);
    beat(3'd4, bx, 1'b0); beat(3'd4, bx, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++; if (rxdat_rdy !== 1'b0 || pend_vec !== 8'h00) $display("FAIL mid_rst got=%b/%h exp=0/00", rxdat_rdy, pend_vec); else passes++;
    checks++; if (dataram_wr_vld !== 1'b0 || linefill_done !== 8'h00) $display("FAIL mid_rst_wr got=%b/%h exp=0/00", dataram_wr_vld, linefill_done); else passes++;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (rxdat_rdy !== 1'b1) $display("FAIL mid_rdy got=%b exp=1", rxdat_rdy); else passes++;
    snoop(3'd4, 7'h01, 1'b1);
    beat(3'd4, ba, 1'b0); beat(3'd4, bb, 1'b0); beat(3'd4, bc, 1'b0);
    checks++; if (dataram_wr_vld !== 1'b0) $display("FAIL mid_early_write got=%b exp=0", dataram_wr_vld); else passes++;
    beat(3'd4, bd, 1'b1);
    checks++; if (dataram_wr_data !== {bd, bc, bb, ba}) $display("FAIL mid_data got=%h exp=%h", dataram_wr_data, {bd, bc, bb, ba}); else passes++;
    checks++; if ({dataram_wr_way, dataram_wr_index} !== {1'b1, 7'h01}) $display("FAIL mid_addr got=%b/%h exp=1/01", dataram_wr_way, dataram_wr_index); else passes++;
    @(negedge clk);
    checks++; if (linefill_done !== 8'h10) $display("FAIL mid_done got=%h exp=10", linefill_done); else passes++;
    @(negedge clk);
    checks++; if ({err_unexp, err_proto} !== 2'b00) $display("FAIL mid_err got=%b exp=00", {err_unexp, err_proto}); else passes++;
  endtask

  task automatic test_last_early();
    do_reset();
    snoop(3'd0, 7'h40, 1'b0);
    beat(3'd0, ba, 1'b0);
    checks++; if (err_proto !== 1'b0) $display("FAIL last_no_err got=%b exp=0", err_proto); else passes++;
    beat(3'd0, bb, 1'b1);
    checks++; if (err_proto !== 1'b1) $display("FAIL last_proto got=%b exp=1", err_proto); else passes++;
    checks++; if (dataram_wr_vld !== 1'b0) $display("FAIL last_no_write got=%b exp=0", dataram_wr_vld); else passes++;
    beat(3'd0, bc, 1'b0);
    checks++; if (dataram_wr_vld !== 1'b0) $display("FAIL last_no_write3 got=%b exp=0", dataram_wr_vld); else passes++;
    beat(3'd0, bd, 1'b1);
    checks++; if (dataram_wr_vld !== 1'b1 || dataram_wr_data !== {bd, bc, bb, ba}) $display("FAIL last_write got=%b data=%h", dataram_wr_vld, dataram_wr_data); else passes++;
    @(negedge clk);
    checks++; if (linefill_done !== 8'h01) $display("FAIL last_done got=%h exp=01", linefill_done); else passes++;
    @(negedge clk);
  endtask

  task automatic test_resnoop_done();
    do_reset();
    snoop(3'd7, 7'h05, 1'b1);
    beat(3'd7, ba, 1'b0); beat(3'd7, bb, 1'b0); beat(3'd7, bc, 1'b0); beat(3'd7, bd, 1'b1);
    @(negedge clk);
    checks++; if (linefill_done !== 8'h80) $display("FAIL resnoop_in_done got=%h exp=80", linefill_done); else passes++;
    snoop(3'd7, 7'h06, 1'b0);
    checks++; if (pend_vec !== 8'h80) $display("FAIL resnoop_pend got=%h exp=80", pend_vec); else passes++;
    checks++; if (err_proto !== 1'b0) $display("FAIL resnoop_no_err got=%b exp=0", err_proto); else passes++;
    snoop(3'd7, 7'h07, 1'b0);
    checks++; if (err_proto !== 1'b1 || pend_vec !== 8'h80) $display("FAIL dup_snoop got=%b/%h exp=1/80", err_proto, pend_vec); else passes++;
    beat(3'd7, bd, 1'b0); beat(3'd7, bc, 1'b0); beat(3'd7, bb, 1'b0); beat(3'd7, ba, 1'b1);
    checks++; if ({dataram_wr_way, dataram_wr_index} !== {1'b0, 7'h07}) $display("FAIL dup_overwrite got=%b/%h exp=0/07", dataram_wr_way, dataram_wr_index); else passes++;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_line();
    test_unexpected();
    test_interleave();
    test_backpressure();
    test_reset_midline();
    test_last_early();
    test_resnoop_done();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
